alu_arbiter: RTL
================

# alu_arbiter

Shares the single combinational ALU between `N_REQ` requesters, such as the execute stage and a multi-cycle helper unit. Each requester uses a valid/ready handshake. A round-robin grant selects one request, registers its operands, drives the ALU, registers the result and zero flag, and returns them on a response channel tagged with the requester ID. The block sits between the requesters and the ALU instance, and owns every ALU input.

## Interface
- `BITS_SIZE`, default 32: operand/result width.
- `BITS_SHAMT`, default 5: shift-amount width.
- `BITS_OP`, default 4: ALU opcode width.
- `ID_BITS`, default 1: requester ID width. `N_REQ = 2**ID_BITS` is a localparam.
- `i_clk`  in  1  clock, all state updates on its rising edge.
- `i_rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_req_valid`  in  N_REQ  per-requester request valid.
- `o_req_ready`  out  N_REQ  per-requester accept strobe; at most one bit set.
- `i_req_a`, `i_req_b`  in  N_REQ*BITS_SIZE each  packed operands; requester k occupies slice [k*BITS_SIZE +: BITS_SIZE].
- `i_req_shamt`  in  N_REQ*BITS_SHAMT  packed shift amounts.
- `i_req_flag_shamt`  in  N_REQ  per-requester shamt-select.
- `i_req_op`  in  N_REQ*BITS_OP  packed opcodes.
- `o_alu_data_a`, `o_alu_data_b`  out  BITS_SIZE  ALU operands.
- `o_alu_shamt`  out  BITS_SHAMT  ALU shift amount.
- `o_alu_flag_shamt`  out  1  ALU shamt-select.
- `o_alu_op`  out  BITS_OP  ALU opcode.
- `i_alu_result`  in  BITS_SIZE  ALU result.
- `i_alu_zero`  in  1  ALU zero flag.
- `o_rsp_valid`  out  1  response valid.
- `i_rsp_ready`  in  1  response consumer ready.
- `o_rsp_id`  out  ID_BITS  index of the requester that owns the response.
- `o_rsp_result`  out  BITS_SIZE  registered result.
- `o_rsp_zero`  out  1  registered zero flag.
- `o_busy`  out  1  high in any state other than IDLE.

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- **IDLE**
  - The grant is computed combinationally from `i_req_valid` and the `last_grant` pointer.
  - Search order is `last_grant+1`, `last_grant+2`, …, wrapping modulo N_REQ.
  - If any request is valid, `o_req_ready[g]` = 1 for this cycle only.
  - On the clock edge: capture a/b/shamt/flag/op of requester g into operand registers, set `last_grant` ← g, set `rsp_id` ← g, go to EXEC.
  - If no request is valid, stay in IDLE.
- **EXEC**
  - The ALU outputs are driven from the operand registers (they always are, in every state).
  - On the clock edge: `o_rsp_result` ← `i_alu_result`, `o_rsp_zero` ← `i_alu_zero`, go to RESP.
- **RESP**
  - `o_rsp_valid` = 1.
  - If `i_rsp_ready` = 1, go to IDLE on the clock edge. Otherwise hold, with all response fields stable.
- The block is opcode-agnostic. Opcodes and operands pass unmodified; unknown opcodes are not filtered.
- `o_req_ready` is 0 in EXEC and RESP. A requester must hold valid and its payload until it sees ready; payload changes before the grant are permitted.
- Requester valid/payload is sampled only in the IDLE grant cycle.

## Timing
- Reset (async, `i_rst_n` = 0):
  - state = IDLE, `last_grant` = N_REQ-1, so requester 0 has first priority.
  - Operand registers, `o_alu_*`, `o_rsp_result`, `o_rsp_zero`, `o_rsp_id`, `o_rsp_valid`, `o_busy` and `o_req_ready` all = 0.
- Latency: grant cycle T, result registered at T+1, `o_rsp_valid` high from T+2.
- Best-case throughput is one operation per 3 cycles (`i_rsp_ready` held high).
- RESP → IDLE: the next grant happens in the cycle after the response handshake. There is no same-cycle overlap.
- Simultaneous requests: exactly one grant per IDLE cycle, in rotating order. With all N_REQ requesting continuously, each is served once per N_REQ operations.
- A reset asserted in EXEC or RESP discards the transaction. No response is produced, and the requester's handshake was already completed.
- `i_rsp_ready` outside RESP is ignored.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`
  - Defined: the grant is the lowest-indexed valid requester, and `last_grant` is still updated but unused.
  - Undefined (default): round-robin as above.
- All other behaviour is identical in both builds.

## Test plan
- Single ADD: req0 with a=5, b=7, op=0000 in IDLE -> `o_req_ready` = 01 in the same cycle; 2 cycles later `o_rsp_valid` = 1, result = 12, zero = 0, id = 0.
- Zero flag: req1 with SUB, a=9, b=9 -> result = 0, zero = 1, id = 1.
- Round-robin: after reset, both valid continuously with `i_rsp_ready` = 1 -> response ids are 0, 1, 0, 1, with grants 3 cycles apart.
- Backpressure: `i_rsp_ready` = 0 for 5 cycles in RESP -> `o_rsp_valid`/result/id stay stable, `o_req_ready` = 0 throughout; ready = 1 -> IDLE next cycle, then a new grant.
- Reset mid-EXEC: assert `i_rst_n` = 0 while `o_busy` = 1 -> all outputs 0 immediately; after release, with both requesting, the first grant is req0.
- With `ALU_ARB_FIXED_PRIO_EN`: both valid continuously -> every response id is 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between N_REQ requesters.
// Define ALU_ARB_FIXED_PRIO_EN to grant the lowest-indexed valid requester instead.
module alu_arbiter #(
  parameter int BITS_SIZE  = 32,
  parameter int BITS_SHAMT = 5,
  parameter int BITS_OP    = 4,
  parameter int ID_BITS    = 1,
  localparam int N_REQ     = 2 ** ID_BITS
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [N_REQ-1:0]              i_req_valid,
  output logic [N_REQ-1:0]              o_req_ready,
  input  logic [N_REQ*BITS_SIZE-1:0]    i_req_a,
  input  logic [N_REQ*BITS_SIZE-1:0]    i_req_b,
  input  logic [N_REQ*BITS_SHAMT-1:0]   i_req_shamt,
  input  logic [N_REQ-1:0]              i_req_flag_shamt,
  input  logic [N_REQ*BITS_OP-1:0]      i_req_op,
  output logic [BITS_SIZE-1:0]          o_alu_data_a,
  output logic [BITS_SIZE-1:0]          o_alu_data_b,
  output logic [BITS_SHAMT-1:0]         o_alu_shamt,
  output logic                          o_alu_flag_shamt,
  output logic [BITS_OP-1:0]            o_alu_op,
  input  logic [BITS_SIZE-1:0]          i_alu_result,
  input  logic                          i_alu_zero,
  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  output logic [ID_BITS-1:0]            o_rsp_id,
  output logic [BITS_SIZE-1:0]          o_rsp_result,
  output logic                          o_rsp_zero,
  output logic                          o_busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                  state_reg;
  logic [ID_BITS-1:0]      last_grant_reg;
  logic [BITS_SIZE-1:0]    op_a_reg;
  logic [BITS_SIZE-1:0]    op_b_reg;
  logic [BITS_SHAMT-1:0]   op_shamt_reg;
  logic                    op_flag_reg;
  logic [BITS_OP-1:0]      op_code_reg;
  logic                    rsp_valid_reg;
  logic [ID_BITS-1:0]      rsp_id_reg;
  logic [BITS_SIZE-1:0]    rsp_result_reg;
  logic                    rsp_zero_reg;
  logic                    busy_reg;

  logic [BITS_SIZE-1:0]    req_a_arr     [N_REQ];
  logic [BITS_SIZE-1:0]    req_b_arr     [N_REQ];
  logic [BITS_SHAMT-1:0]   req_shamt_arr [N_REQ];
  logic [BITS_OP-1:0]      req_op_arr    [N_REQ];

  logic                    grant_any;
  logic [ID_BITS-1:0]      grant_idx;
  logic [ID_BITS-1:0]      rr_idx;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_a_arr[gi]     = i_req_a[gi*BITS_SIZE +: BITS_SIZE];
      assign req_b_arr[gi]     = i_req_b[gi*BITS_SIZE +: BITS_SIZE];
      assign req_shamt_arr[gi] = i_req_shamt[gi*BITS_SHAMT +: BITS_SHAMT];
      assign req_op_arr[gi]    = i_req_op[gi*BITS_OP +: BITS_OP];
    end
  endgenerate

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Scan downwards so the lowest valid index is the one left standing.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    rr_idx    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req_valid[k]) begin
        grant_any = 1'b1;
        grant_idx = ID_BITS'(k);
      end
    end
  end
`else
  // Search starts just after the last winner; ID_BITS-wide addition wraps naturally.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    rr_idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      rr_idx = last_grant_reg + ID_BITS'(k);
      if (!grant_any && i_req_valid[rr_idx]) begin
        grant_any = 1'b1;
        grant_idx = rr_idx;
      end
    end
  end
`endif

  // Gated by reset so no requester sees an accept while the block is held in reset.
  assign o_req_ready = (state_reg == IDLE && grant_any && i_rst_n)
                     ? (N_REQ'(1) << grant_idx) : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= '1;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      op_shamt_reg   <= '0;
      op_flag_reg    <= 1'b0;
      op_code_reg    <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= '0;
      rsp_result_reg <= '0;
      rsp_zero_reg   <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            op_a_reg       <= req_a_arr[grant_idx];
            op_b_reg       <= req_b_arr[grant_idx];
            op_shamt_reg   <= req_shamt_arr[grant_idx];
            op_flag_reg    <= i_req_flag_shamt[grant_idx];
            op_code_reg    <= req_op_arr[grant_idx];
            last_grant_reg <= grant_idx;
            rsp_id_reg     <= grant_idx;
            busy_reg       <= 1'b1;
            state_reg      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_reg <= i_alu_result;
          rsp_zero_reg   <= i_alu_zero;
          rsp_valid_reg  <= 1'b1;
          state_reg      <= RESP;
        end
        RESP: begin
          if (i_rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          rsp_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign o_alu_data_a     = op_a_reg;
  assign o_alu_data_b     = op_b_reg;
  assign o_alu_shamt      = op_shamt_reg;
  assign o_alu_flag_shamt = op_flag_reg;
  assign o_alu_op         = op_code_reg;
  assign o_rsp_valid      = rsp_valid_reg;
  assign o_rsp_id         = rsp_id_reg;
  assign o_rsp_result     = rsp_result_reg;
  assign o_rsp_zero       = rsp_zero_reg;
  assign o_busy           = busy_reg;

endmodule
